// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU.
//   - OP_* : 3-bit opcode map (unchanged from the combinational ALU)
//   - FLAG_*: bit positions inside the packed flag vector that travels from
//             the combinational core into the S2 register
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_ADDC = 3'b111;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;
  localparam int NUM_FLAGS  = 4;

  // Ops whose carry out is remembered for a following ADDC.
  function automatic logic op_updates_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDC);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// ----------------------------------------------------------------------------
// alu_pipe_core
// Purely combinational ALU datapath evaluated between the S1 and S2 registers.
// Ports:
//   a_i, b_i   [WIDTH-1:0]  operands
//   opcode_i   [2:0]        operation select (alu_pkg::OP_*)
//   cin_i                   stored carry, only consumed by ADDC
//   result_o   [WIDTH-1:0]  operation result
//   flags_o    [3:0]        zero/carry/overflow/negative, indexed by FLAG_*
// ----------------------------------------------------------------------------
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [2:0]           opcode_i,
  input  logic                 cin_i,
  output logic [WIDTH-1:0]     result_o,
  output logic [NUM_FLAGS-1:0] flags_o
);

  localparam int MSB = WIDTH - 1;

  logic             cin_eff;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;

  assign cin_eff = (opcode_i == OP_ADDC) && cin_i;

  // One extra bit on both the sum and the difference: bit WIDTH is the
  // carry out for addition and the borrow (A < B unsigned) for subtraction.
  assign add_ext = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_eff};
  assign sub_ext = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (opcode_i)
      OP_ADD, OP_ADDC: begin
        result = add_ext[WIDTH-1:0];
        carry  = add_ext[WIDTH];
        ovf    = (a_i[MSB] == b_i[MSB]) && (result[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        result = sub_ext[WIDTH-1:0];
        carry  = sub_ext[WIDTH];
        ovf    = (a_i[MSB] != b_i[MSB]) && (result[MSB] != a_i[MSB]);
      end
      OP_AND:  result = a_i & b_i;
      OP_OR:   result = a_i | b_i;
      OP_XOR:  result = a_i ^ b_i;
      OP_NOT:  result = ~a_i;
      // The borrow of A-B is exactly the unsigned A<B comparison.
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, sub_ext[WIDTH]};
      default: result = '0;
    endcase
  end

  assign result_o            = result;
  assign flags_o[FLAG_ZERO]  = (result == '0);
  assign flags_o[FLAG_CARRY] = carry;
  assign flags_o[FLAG_OVF]   = ovf;
  assign flags_o[FLAG_NEG]   = result[MSB];

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   S1 captures operands/opcode on an input handshake; the core evaluates
//   S1 and the result/flags are captured into S2 when S1 advances.
// Parameters:
//   WIDTH (2..64)  operand/result width
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   in_valid / in_ready        upstream handshake
//   A, B [WIDTH-1:0], opcode   operation
//   out_valid / out_ready      downstream handshake
//   results [WIDTH-1:0]        registered result
//   zero_flag, carry_flag, overflow_flag, negative_flag  registered flags
// ----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] results,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag
);

  // S1 stage
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [2:0]       s1_op_q,    s1_op_d;

  // S2 stage
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     results_q,   results_d;
  logic [NUM_FLAGS-1:0] flags_q,     flags_d;

  // Carry remembered for ADDC chains
  logic carry_q, carry_d;

  logic                 stall;
  logic                 in_accept;
  logic                 s1_advance;
  logic [WIDTH-1:0]     core_result;
  logic [NUM_FLAGS-1:0] core_flags;

  alu_pipe_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .opcode_i (s1_op_q),
    .cin_i    (carry_q),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  // S2 only blocks when it holds a result nobody takes. in_ready looks
  // through to out_ready so a full pipeline keeps streaming without bubbles.
  assign stall      = out_valid_q && !out_ready;
  assign in_ready   = !s1_valid_q || !stall;
  assign in_accept  = in_valid && in_ready;
  assign s1_advance = s1_valid_q && !stall;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    results_d   = results_q;
    flags_d     = flags_q;
    carry_d     = carry_q;

    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = A;
      s1_b_d     = B;
      s1_op_d    = opcode;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    // carry_q is updated on the same edge the op lands in S2, so an ADDC
    // directly behind it in S1 already sees the new carry.
    if (s1_advance) begin
      out_valid_d = 1'b1;
      results_d   = core_result;
      flags_d     = core_flags;
      if (op_updates_carry(s1_op_q)) begin
        carry_d = core_flags[FLAG_CARRY];
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q          <= 1'b0;
      s1_a_q              <= '0;
      s1_b_q              <= '0;
      s1_op_q             <= OP_ADD;
      out_valid_q         <= 1'b0;
      results_q           <= '0;
      flags_q             <= '0;
      flags_q[FLAG_ZERO]  <= 1'b1;  // consistent with results == 0
      carry_q             <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      results_q   <= results_d;
      flags_q     <= flags_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign results       = results_q;
  assign zero_flag     = flags_q[FLAG_ZERO];
  assign carry_flag    = flags_q[FLAG_CARRY];
  assign overflow_flag = flags_q[FLAG_OVF];
  assign negative_flag = flags_q[FLAG_NEG];

endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
// Directed scenarios plus randomized traffic for alu_pipe (WIDTH=4). A queue
// of expected results, computed with plain integer arithmetic in the order
// operations are accepted, is compared against every output handshake.
// ----------------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W    = 4;
  localparam int FULL = 1 << W;
  localparam int HALF = FULL / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] results;
  logic         zero_flag;
  logic         carry_flag;
  logic         overflow_flag;
  logic         negative_flag;

  alu_pipe #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (A),
    .B             (B),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .results       (results),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         n;
  } exp_t;

  exp_t     exp_q[$];
  int       m_carry = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  int       pops = 0;
  exp_t     last_obs;
  logic     prev_stall = 1'b0;
  logic [W+4:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: signed/unsigned arithmetic on plain integers.
  function automatic exp_t model(input logic [W-1:0] a_l, input logic [W-1:0] b_l,
                                 input logic [2:0] op);
    exp_t e;
    int a, b, sa, sb, s, ss, r;
    a  = int'(a_l);
    b  = int'(b_l);
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    e  = '0;
    r  = 0;
    case (op)
      OP_ADD, OP_ADDC: begin
        s  = a + b + ((op == OP_ADDC) ? m_carry : 0);
        ss = sa + sb + ((op == OP_ADDC) ? m_carry : 0);
        r  = s % FULL;
        e.c = (s >= FULL);
        e.v = (ss < -HALF) || (ss >= HALF);
        m_carry = int'(e.c);
      end
      OP_SUB: begin
        r  = (a - b + FULL) % FULL;
        ss = sa - sb;
        e.c = (a < b);
        e.v = (ss < -HALF) || (ss >= HALF);
        m_carry = int'(e.c);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = (FULL - 1) - a;
      OP_SLTU: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    e.res = W'(r);
    e.z   = (r == 0);
    e.n   = (r >= HALF);
    return e;
  endfunction

  // One clock cycle: drive inputs, score at the negedge, return #1 after posedge.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic rdy);
    exp_t e;
    logic [W+4:0] cur;
    in_valid  = v;
    A         = a;
    B         = b;
    opcode    = op;
    out_ready = rdy;
    @(negedge clk);
    cur = {out_valid, results, zero_flag, carry_flag, overflow_flag, negative_flag};
    if (prev_stall) check("stall_hold", cur, held);
    prev_stall = out_valid && !out_ready;
    held = cur;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_with_empty_queue", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("res",   results,       e.res);
        check("zero",  zero_flag,     e.z);
        check("carry", carry_flag,    e.c);
        check("ovf",   overflow_flag, e.v);
        check("neg",   negative_flag, e.n);
        last_obs = {results, zero_flag, carry_flag, overflow_flag, negative_flag};
        pops++;
        $display("txn %0d: res=%b z=%b c=%b v=%b n=%b", pops, results, zero_flag,
                 carry_flag, overflow_flag, negative_flag);
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
  endtask

  // Single op into an empty pipeline, checking the two-register latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int p0;
    p0 = pops;
    cycle(1'b1, a, b, op, 1'b1);
    check("lat_s1", out_valid, 0);
    cycle(1'b0, '0, '0, OP_ADD, 1'b1);
    check("lat_s2", out_valid, 1);
    cycle(1'b0, '0, '0, OP_ADD, 1'b1);
    check("one_pop", pops - p0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, OP_ADD, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = OP_ADD;
    #12;
    check("rst_state", {out_valid, results, zero_flag, carry_flag, overflow_flag, negative_flag},
          {1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_after_rst", in_ready, 1);

    // Basic ADD and SUB with borrow
    do_op(4'b0010, 4'b0001, OP_ADD);
    check("add_basic", last_obs, {4'b0011, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op(4'b0010, 4'b0011, OP_SUB);
    check("sub_borrow", last_obs, {4'b1111, 1'b0, 1'b1, 1'b0, 1'b1});

    // Multi-word chain: ADD then ADDC back-to-back
    cycle(1'b1, 4'b1111, 4'b0001, OP_ADD, 1'b1);
    cycle(1'b1, 4'b0000, 4'b0000, OP_ADDC, 1'b1);
    cycle(1'b0, '0, '0, OP_ADD, 1'b1);
    check("chain_lo", last_obs, {4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
    cycle(1'b0, '0, '0, OP_ADD, 1'b1);
    check("chain_hi", last_obs, {4'b0001, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(1);

    // Backpressure: three ops while downstream is blocked
    cycle(1'b1, 4'b1100, 4'b1010, OP_AND, 1'b0);
    cycle(1'b1, 4'b1100, 4'b1010, OP_OR, 1'b0);
    check("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1100, 4'b1010, OP_XOR, 1'b0);
    check("bp_still_low", in_ready, 0);
    check("bp_head_visible", {out_valid, results}, {1'b1, 4'b1000});
    cycle(1'b1, 4'b1100, 4'b1010, OP_XOR, 1'b1);
    check("bp_first", last_obs.res, 4'b1000);
    cycle(1'b0, '0, '0, OP_ADD, 1'b1);
    check("bp_second", last_obs.res, 4'b1110);
    cycle(1'b0, '0, '0, OP_ADD, 1'b1);
    check("bp_third", last_obs.res, 4'b0110);
    check("bp_drained", out_valid, 0);

    // Signed overflow and SLTU
    do_op(4'b0111, 4'b0001, OP_ADD);
    check("ovf_add", last_obs, {4'b1000, 1'b0, 1'b0, 1'b1, 1'b1});
    do_op(4'b0001, 4'b0010, OP_SLTU);
    check("sltu_lt", last_obs, {4'b0001, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op(4'b0100, 4'b0010, OP_SLTU);
    check("sltu_ge", last_obs, {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});

    // Reset with two ops in flight after carry_q was set
    do_op(4'b1111, 4'b0001, OP_ADD);
    check("pre_rst_carry", last_obs.c, 1);
    cycle(1'b1, 4'b0011, 4'b0011, OP_ADD, 1'b1);
    cycle(1'b1, 4'b0101, 4'b0101, OP_SUB, 1'b1);
    check("inflight_valid", out_valid, 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst", {out_valid, results, zero_flag, carry_flag, overflow_flag, negative_flag},
          {1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    exp_q.delete();
    m_carry    = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rdy", in_ready, 1);
    check("rst_no_stale", out_valid, 0);
    do_op(4'b0001, 4'b0001, OP_ADDC);
    check("addc_after_rst", last_obs, {4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom_range(0, FULL - 1)),
            W'($urandom_range(0, FULL - 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7));
    end
    idle(6);
    check("drain_empty", exp_q.size(), 0);
    check("final_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
